// File: rtl/ram_arbiter.sv
// Arbiter sharing the data-RAM slave port between CPU and DMA masters.
// Define ARB_FAIRNESS_EN for round-robin; otherwise CPU has fixed priority.
module ram_arbiter #(
   parameter int ADDR_WIDTH   = 32,
   parameter int DATA_WIDTH   = 32,
   parameter int RESP_TIMEOUT = 255
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  cpuReqValid,
   output logic                  cpuReqReady,
   input  logic                  cpuReqWrite,
   input  logic [ADDR_WIDTH-1:0] cpuReqAddress,
   input  logic [DATA_WIDTH-1:0] cpuReqWriteData,
   output logic                  cpuRespValid,
   output logic [DATA_WIDTH-1:0] cpuRespData,
   output logic                  cpuRespError,
   input  logic                  dmaReqValid,
   output logic                  dmaReqReady,
   input  logic                  dmaReqWrite,
   input  logic [ADDR_WIDTH-1:0] dmaReqAddress,
   input  logic [DATA_WIDTH-1:0] dmaReqWriteData,
   output logic                  dmaRespValid,
   output logic [DATA_WIDTH-1:0] dmaRespData,
   output logic                  dmaRespError,
   output logic                  ramReqValid,
   input  logic                  ramReqReady,
   output logic                  ramReqWrite,
   output logic [ADDR_WIDTH-1:0] ramReqAddress,
   output logic [DATA_WIDTH-1:0] ramReqWriteData,
   input  logic                  ramRespValid,
   input  logic [DATA_WIDTH-1:0] ramRespData,
   output logic                  busy,
   output logic                  ownerIsDma
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESP} state_t;

   localparam int CNT_W = (RESP_TIMEOUT > 1) ? $clog2(RESP_TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT =
      CNT_W'((RESP_TIMEOUT > 0) ? RESP_TIMEOUT - 1 : 0);

   state_t                state, stateNext;
   logic                  latchedWrite;
   logic [ADDR_WIDTH-1:0] latchedAddress;
   logic [DATA_WIDTH-1:0] latchedData;
   logic                  ownerDma;
   logic [CNT_W-1:0]      counter;
   logic                  anyValid;
   logic                  dmaWins;
   logic                  timedOut;
   logic                  respFire;
   logic                  respErr;
   logic [DATA_WIDTH-1:0] respData;

   assign anyValid = cpuReqValid | dmaReqValid;

`ifdef ARB_FAIRNESS_EN
   logic lastGrantDma;

   // On a tie, the master that was not granted last wins
   assign dmaWins = dmaReqValid & (~cpuReqValid | ~lastGrantDma);

   always_ff @(posedge clock) begin
      if (reset) begin
         lastGrantDma <= 1'b1;
      end else if (state == IDLE && anyValid) begin
         lastGrantDma <= dmaWins;
      end
   end
`else
   assign dmaWins = dmaReqValid & ~cpuReqValid;
`endif

   assign timedOut = (RESP_TIMEOUT != 0) && (counter == LAST_CNT);

   always_comb begin
      stateNext    = state;
      cpuReqReady  = 1'b0;
      dmaReqReady  = 1'b0;
      ramReqValid  = 1'b0;
      respFire     = 1'b0;
      respErr      = 1'b0;
      respData     = '0;
      if (!reset) begin
         unique case (state)
            IDLE: begin
               if (anyValid) begin
                  cpuReqReady = ~dmaWins;
                  dmaReqReady = dmaWins;
                  stateNext   = ISSUE;
               end
            end
            ISSUE: begin
               ramReqValid = 1'b1;
               if (ramReqReady) stateNext = WAIT_RESP;
            end
            WAIT_RESP: begin
               if (ramRespValid) begin
                  respFire  = 1'b1;
                  respData  = latchedWrite ? '0 : ramRespData;
                  stateNext = IDLE;
               end else if (timedOut) begin
                  respFire  = 1'b1;
                  respErr   = 1'b1;
                  stateNext = IDLE;
               end
            end
            default: stateNext = IDLE;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state          <= IDLE;
         latchedWrite   <= 1'b0;
         latchedAddress <= '0;
         latchedData    <= '0;
         ownerDma       <= 1'b0;
         counter        <= '0;
      end else begin
         state <= stateNext;
         if (state == IDLE && anyValid) begin
            latchedWrite   <= dmaWins ? dmaReqWrite : cpuReqWrite;
            latchedAddress <= dmaWins ? dmaReqAddress : cpuReqAddress;
            latchedData    <= dmaWins ? dmaReqWriteData : cpuReqWriteData;
            ownerDma       <= dmaWins;
         end
         // Saturating so a long stall never wraps back below the limit
         if (state == ISSUE) begin
            counter <= '0;
         end else if (state == WAIT_RESP && counter != '1) begin
            counter <= counter + 1'b1;
         end
      end
   end

   assign ramReqWrite     = latchedWrite;
   assign ramReqAddress   = latchedAddress;
   assign ramReqWriteData = latchedData;

   assign cpuRespValid = respFire & ~ownerDma;
   assign cpuRespError = respErr & ~ownerDma;
   assign cpuRespData  = ownerDma ? '0 : respData;
   assign dmaRespValid = respFire & ownerDma;
   assign dmaRespError = respErr & ownerDma;
   assign dmaRespData  = ownerDma ? respData : '0;

   assign busy       = (state != IDLE);
   assign ownerIsDma = ownerDma;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: vector table plus multi-cycle sequences.
module tb_ram_arbiter;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        cpuReqValid = 0, cpuReqWrite = 0;
   logic [31:0] cpuReqAddress = 0, cpuReqWriteData = 0;
   logic        dmaReqValid = 0, dmaReqWrite = 0;
   logic [31:0] dmaReqAddress = 0, dmaReqWriteData = 0;
   logic        ramReqReady = 0, ramRespValid = 0;
   logic [31:0] ramRespData = 0;
   logic        cpuReqReady, cpuRespValid, cpuRespError;
   logic [31:0] cpuRespData;
   logic        dmaReqReady, dmaRespValid, dmaRespError;
   logic [31:0] dmaRespData;
   logic        ramReqValid, ramReqWrite;
   logic [31:0] ramReqAddress, ramReqWriteData;
   logic        busy, ownerIsDma;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   ram_arbiter #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .RESP_TIMEOUT(8)
   ) dut (
      .clock(clock), .reset(reset),
      .cpuReqValid(cpuReqValid), .cpuReqReady(cpuReqReady),
      .cpuReqWrite(cpuReqWrite), .cpuReqAddress(cpuReqAddress),
      .cpuReqWriteData(cpuReqWriteData), .cpuRespValid(cpuRespValid),
      .cpuRespData(cpuRespData), .cpuRespError(cpuRespError),
      .dmaReqValid(dmaReqValid), .dmaReqReady(dmaReqReady),
      .dmaReqWrite(dmaReqWrite), .dmaReqAddress(dmaReqAddress),
      .dmaReqWriteData(dmaReqWriteData), .dmaRespValid(dmaRespValid),
      .dmaRespData(dmaRespData), .dmaRespError(dmaRespError),
      .ramReqValid(ramReqValid), .ramReqReady(ramReqReady),
      .ramReqWrite(ramReqWrite), .ramReqAddress(ramReqAddress),
      .ramReqWriteData(ramReqWriteData), .ramRespValid(ramRespValid),
      .ramRespData(ramRespData), .busy(busy), .ownerIsDma(ownerIsDma)
   );

   typedef struct {
      logic [3:0]  ctl;
      logic [31:0] ca, cd, da, dd;
      logic        rrdy, rrv;
      logic [31:0] rrd;
      logic [1:0]  eRdy;
      logic        eRv, eRw;
      logic [31:0] eAddr, eWd;
      logic        eCv;
      logic [31:0] eCd;
      logic        eCe, eDv;
      logic [31:0] eDd;
      logic        eDe, eBusy, eOwn;
   } vec_t;

   vec_t vecs[21];

   function automatic logic [159:0] actual();
      return 160'({cpuReqReady, dmaReqReady, ramReqValid, ramReqWrite,
                   ramReqAddress, ramReqWriteData, cpuRespValid, cpuRespData,
                   cpuRespError, dmaRespValid, dmaRespData, dmaRespError,
                   busy, ownerIsDma});
   endfunction

   function automatic logic [159:0] expected(vec_t v);
      return 160'({v.eRdy, v.eRv, v.eRw, v.eAddr, v.eWd, v.eCv, v.eCd,
                   v.eCe, v.eDv, v.eDd, v.eDe, v.eBusy, v.eOwn});
   endfunction

   task automatic check(string name, logic [159:0] act, logic [159:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic apply(vec_t v);
      {cpuReqValid, cpuReqWrite, dmaReqValid, dmaReqWrite} = v.ctl;
      cpuReqAddress   = v.ca;
      cpuReqWriteData = v.cd;
      dmaReqAddress   = v.da;
      dmaReqWriteData = v.dd;
      ramReqReady     = v.rrdy;
      ramRespValid    = v.rrv;
      ramRespData     = v.rrd;
   endtask

   task automatic clearInputs();
      apply('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
   endtask

   initial begin
      int waitCycles;
      int grants;
      bit justGranted;
      bit lastWasDma;
      logic [1:0] expDma;

      // ctl = {cpuValid, cpuWrite, dmaValid, dmaWrite}
      vecs[0]  = '{4'b1000, 'h100, 0, 0, 0, 1, 0, 0,
                   2'b10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      vecs[1]  = '{4'b0000, 'h100, 0, 0, 0, 1, 0, 0,
                   2'b00, 1, 0, 'h100, 0, 0, 0, 0, 0, 0, 0, 1, 0};
      vecs[2]  = '{4'b0000, 'h100, 0, 0, 0, 1, 1, 'hDEADBEEF,
                   2'b00, 0, 0, 'h100, 0, 1, 'hDEADBEEF, 0, 0, 0, 0, 1, 0};
      vecs[3]  = '{4'b0000, 0, 0, 0, 0, 0, 0, 0,
                   2'b00, 0, 0, 'h100, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      vecs[4]  = '{4'b0011, 0, 0, 'h40, 'h55AA, 0, 0, 0,
                   2'b01, 0, 0, 'h100, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      for (int i = 5; i <= 9; i++)
         vecs[i] = '{4'b0000, 0, 0, 'hFFF, 'h1111, 0, 0, 0,
                     2'b00, 1, 1, 'h40, 'h55AA, 0, 0, 0, 0, 0, 0, 1, 1};
      vecs[10] = '{4'b0000, 0, 0, 'hFFF, 'h1111, 1, 0, 0,
                   2'b00, 1, 1, 'h40, 'h55AA, 0, 0, 0, 0, 0, 0, 1, 1};
      vecs[11] = '{4'b0000, 0, 0, 0, 0, 0, 0, 0,
                   2'b00, 0, 1, 'h40, 'h55AA, 0, 0, 0, 0, 0, 0, 1, 1};
      vecs[12] = '{4'b0000, 0, 0, 0, 0, 0, 1, 'h1234,
                   2'b00, 0, 1, 'h40, 'h55AA, 0, 0, 0, 1, 0, 0, 1, 1};
      vecs[13] = '{4'b1110, 'h200, 'hCAFE, 'h300, 0, 0, 0, 0,
                   2'b10, 0, 1, 'h40, 'h55AA, 0, 0, 0, 0, 0, 0, 0, 1};
      vecs[14] = '{4'b0010, 'h200, 'hCAFE, 'h300, 0, 0, 0, 0,
                   2'b00, 1, 1, 'h200, 'hCAFE, 0, 0, 0, 0, 0, 0, 1, 0};
      vecs[15] = '{4'b0010, 'h200, 'hCAFE, 'h300, 0, 1, 0, 0,
                   2'b00, 1, 1, 'h200, 'hCAFE, 0, 0, 0, 0, 0, 0, 1, 0};
      vecs[16] = '{4'b0010, 'h200, 'hCAFE, 'h300, 0, 0, 1, 'h7777,
                   2'b00, 0, 1, 'h200, 'hCAFE, 1, 0, 0, 0, 0, 0, 1, 0};
      vecs[17] = '{4'b0010, 'h200, 'hCAFE, 'h300, 0, 0, 0, 0,
                   2'b01, 0, 1, 'h200, 'hCAFE, 0, 0, 0, 0, 0, 0, 0, 0};
      vecs[18] = '{4'b0000, 0, 0, 0, 0, 1, 0, 0,
                   2'b00, 1, 0, 'h300, 0, 0, 0, 0, 0, 0, 0, 1, 1};
      vecs[19] = '{4'b0000, 0, 0, 0, 0, 0, 1, 'hA5A5A5A5,
                   2'b00, 0, 0, 'h300, 0, 0, 0, 0, 1, 'hA5A5A5A5, 0, 1, 1};
      vecs[20] = '{4'b0000, 0, 0, 0, 0, 0, 1, 'h9,
                   2'b00, 0, 0, 'h300, 0, 0, 0, 0, 0, 0, 0, 0, 1};

      clearInputs();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      @(negedge clock);
      check("reset_state", actual(), 160'd0);
      step();

      foreach (vecs[i]) begin
         apply(vecs[i]);
         @(negedge clock);
         check($sformatf("vec%0d", i), actual(), expected(vecs[i]));
         step();
      end

      // Response timeout on a DMA write the slave never answers
      clearInputs();
      dmaReqValid = 1; dmaReqWrite = 1;
      dmaReqAddress = 'h40; dmaReqWriteData = 'h77;
      ramReqReady = 1;
      @(negedge clock);
      check("to_grant", 160'(dmaReqReady), 160'd1);
      step();
      dmaReqValid = 0;
      step();
      waitCycles = 0;
      for (int n = 1; n <= 20; n++) begin
         @(negedge clock);
         if (dmaRespValid) begin
            waitCycles = n;
            break;
         end
         step();
      end
      check("to_cycles", 160'(waitCycles), 160'd8);
      check("to_resp", 160'({dmaRespError, dmaRespData, cpuRespValid}),
            160'({1'b1, 32'd0, 1'b0}));
      step();
      @(negedge clock);
      check("to_idle", 160'({busy, ramReqValid}), 160'd0);
      step();

      // Reset while a CPU read waits for its response
      clearInputs();
      cpuReqValid = 1; cpuReqAddress = 'h500; ramReqReady = 1;
      step();
      cpuReqValid = 0;
      step();
      @(negedge clock);
      check("rst_inwait", 160'({busy, ramReqValid}), 160'({1'b1, 1'b0}));
      step();
      reset = 1; ramRespValid = 1; ramRespData = 'hBAD;
      @(negedge clock);
      check("rst_pulse", 160'({cpuRespValid, dmaRespValid}), 160'd0);
      step();
      reset = 0;
      @(negedge clock);
      check("rst_after", actual(), 160'd0);
      step();
      @(negedge clock);
      check("rst_late", actual(), 160'd0);
      step();

      // Both masters requesting continuously for four grants
      clearInputs();
      cpuReqValid = 1; cpuReqAddress = 'h600;
      dmaReqValid = 1; dmaReqAddress = 'h700;
      ramReqReady = 1; ramRespValid = 1; ramRespData = 'h1;
      grants = 0;
      lastWasDma = 0;
      for (int c = 0; c < 30 && grants < 4; c++) begin
         justGranted = 0;
         @(negedge clock);
         if (cpuReqReady || dmaReqReady) begin
`ifdef ARB_FAIRNESS_EN
            expDma = {1'b0, grants[0]};
`else
            expDma = 2'b00;
`endif
            check($sformatf("rr_grant%0d", grants),
                  160'({cpuReqReady, dmaReqReady}),
                  160'({~expDma[0], expDma[0]}));
            lastWasDma = expDma[0];
            justGranted = 1;
            grants++;
         end
         step();
         if (justGranted) begin
            check($sformatf("rr_owner%0d", grants - 1),
                  160'({ownerIsDma, ramReqValid}),
                  160'({lastWasDma, 1'b1}));
            if (grants == 4) begin
               cpuReqValid = 0;
               dmaReqValid = 0;
            end
         end
      end
      check("rr_count", 160'(grants), 160'd4);
      step();
      step();
      @(negedge clock);
      check("rr_idle", 160'(busy), 160'd0);
      clearInputs();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
